// File: rtl/muldiv_scheduler_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler:
// op codes, FSM state encoding and small op-class helpers.
package muldiv_scheduler_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] code);
    return (code == OP_DIV) || (code == OP_DIVU);
  endfunction

  // Signed variants are the even codes of each pair.
  function automatic logic is_signed_op(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_scheduler_lat_counter.sv
// Cycle counter that paces the fixed-latency multiplier. Held at zero
// while cleared, counts while enabled, flags the last latency cycle.
module muldiv_lat_counter #(
  parameter int MUL_LAT = 3,
  parameter int W_CNT   = $clog2(MUL_LAT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [W_CNT-1:0] cnt_q;

  // Count register: clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W_CNT'(1);
    end
  end

  assign term_o = (cnt_q == W_CNT'(MUL_LAT - 1));

endmodule

// File: rtl/muldiv_scheduler.sv
// HI/LO arithmetic scheduler. Takes one op at a time from EX, drives the
// external pipelined multiplier or iterative divider, and commits the
// result pair into the architectural HI/LO registers once the bus is free.
//
// Handshake: an op transfers on a rising clk edge where op_valid & op_ready
// are both high; op_ready is high only in IDLE, so at most one op is in
// flight. op_done pulses for one cycle on the HI/LO commit of a MULT*/DIV*
// (including a divide by zero, which commits nothing). flush overrides all
// and returns to IDLE without committing.
module muldiv_scheduler
  import muldiv_scheduler_pkg::*;
#(
  parameter int W       = 32,
  parameter int MUL_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  input  logic [2:0]     op_code,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  output logic           op_ready,
  input  logic           flush,
  input  logic           is_busbusy,
  input  logic           hilo_rd,
  output logic           stall_req,
  output logic           mul_ce,
  output logic           mul_sign,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           div_start,
  output logic           div_cancel,
  output logic           div_sign,
  output logic [W-1:0]   div_a,
  output logic [W-1:0]   div_b,
  input  logic           div_done,
  input  logic [W-1:0]   div_q,
  input  logic [W-1:0]   div_r,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           op_done,
  output state_e         dbg_state
);

  state_e         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           sign_q;
  logic [2*W-1:0] result_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           mul_ce_q;
  logic           div_start_q;
  logic           div_cancel_q;
  logic           op_done_q;
  logic           cnt_term;

  muldiv_lat_counter #(
    .MUL_LAT (MUL_LAT)
  ) u_lat_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != ST_MUL),
    .en_i   (state_q == ST_MUL),
    .term_o (cnt_term)
  );

  // Scheduler FSM with all registered outputs; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sign_q       <= 1'b0;
      result_q     <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_ce_q     <= 1'b0;
      div_start_q  <= 1'b0;
      div_cancel_q <= 1'b0;
      op_done_q    <= 1'b0;
    end else begin
      div_start_q  <= 1'b0;
      div_cancel_q <= 1'b0;
      op_done_q    <= 1'b0;
      if (flush) begin
        // Abort: drop any result, only the divider needs an explicit cancel.
        state_q      <= ST_IDLE;
        mul_ce_q     <= 1'b0;
        div_cancel_q <= (state_q == ST_DIV);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (op_valid) begin
              if (is_mul_op(op_code)) begin
                a_q      <= op_a;
                b_q      <= op_b;
                sign_q   <= is_signed_op(op_code);
                mul_ce_q <= 1'b1;
                state_q  <= ST_MUL;
              end else if (is_div_op(op_code)) begin
                if (op_b != '0) begin
                  a_q         <= op_a;
                  b_q         <= op_b;
                  sign_q      <= is_signed_op(op_code);
                  div_start_q <= 1'b1;
                  state_q     <= ST_DIV;
                end else begin
                  // Divide by zero: report completion, leave HI/LO alone.
                  op_done_q <= 1'b1;
                end
              end else if (op_code == OP_MTHI) begin
                hi_q <= op_a;
              end else if (op_code == OP_MTLO) begin
                lo_q <= op_a;
              end
            end
          end
          ST_MUL: begin
            if (cnt_term) begin
              result_q <= mul_p;
              mul_ce_q <= 1'b0;
              state_q  <= ST_HOLD;
            end
          end
          ST_DIV: begin
            if (div_done) begin
              result_q <= {div_r, div_q};
              state_q  <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!is_busbusy) begin
              hi_q      <= result_q[2*W-1:W];
              lo_q      <= result_q[W-1:0];
              op_done_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign op_ready   = (state_q == ST_IDLE);
  assign stall_req  = (state_q != ST_IDLE) && (op_valid || hilo_rd);
  assign mul_ce     = mul_ce_q;
  assign mul_sign   = sign_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign div_start  = div_start_q;
  assign div_cancel = div_cancel_q;
  assign div_sign   = sign_q;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign op_done    = op_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Bench for muldiv_scheduler: behavioural multiplier/divider models on the
// unit ports, directed scenarios plus a randomized back-to-back run.
module tb_muldiv_scheduler;
  import muldiv_scheduler_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 3;

  logic           clk;
  logic           rst;
  logic           op_valid;
  logic [2:0]     op_code;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_ready;
  logic           flush;
  logic           is_busbusy;
  logic           hilo_rd;
  logic           stall_req;
  logic           mul_ce;
  logic           mul_sign;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_p;
  logic           div_start;
  logic           div_cancel;
  logic           div_sign;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic           div_done;
  logic [W-1:0]   div_q;
  logic [W-1:0]   div_r;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           op_done;
  state_e         dbg_state;

  int             n_cmp = 0;
  int             n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model_hi;
  logic [W-1:0]   model_lo;
  int             div_lat;
  logic           stray_done;
  logic [W-1:0]   stray_val;

  muldiv_scheduler #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_ready   (op_ready),
    .flush      (flush),
    .is_busbusy (is_busbusy),
    .hilo_rd    (hilo_rd),
    .stall_req  (stall_req),
    .mul_ce     (mul_ce),
    .mul_sign   (mul_sign),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .div_start  (div_start),
    .div_cancel (div_cancel),
    .div_sign   (div_sign),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_done   (div_done),
    .div_q      (div_q),
    .div_r      (div_r),
    .hi         (hi),
    .lo         (lo),
    .op_done    (op_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0]        q;
    logic [W-1:0]        r;
    sa = a;
    sb = b;
    if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // ---------------- multiplier model: MUL_LAT-1 register stages ----------------
  logic [2*W-1:0] mp1;
  logic [2*W-1:0] mp2;
  always_ff @(posedge clk) begin
    mp1 <= mul_ce ? ref_mul(mul_a, mul_b, mul_sign) : '0;
    mp2 <= mp1;
  end
  assign mul_p = mp2;

  // ---------------- divider model: start/cancel/done ----------------
  logic           m_busy;
  logic           m_done;
  int             m_cnt;
  logic [2*W-1:0] m_res;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (div_cancel) begin
        m_busy <= 1'b0;
      end else if (div_start) begin
        m_busy <= 1'b1;
        m_cnt  <= div_lat;
        m_res  <= ref_div(div_a, div_b, div_sign);
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end
  assign div_done = m_done | stray_done;
  assign div_q    = stray_done ? stray_val : m_res[W-1:0];
  assign div_r    = stray_done ? ~stray_val : m_res[2*W-1:W];

  // ---------------- driver tasks ----------------
  // Present one op for a single cycle; returns on the negedge after the accept edge.
  task automatic issue_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = 1'b1;
    op_code  = c;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'd7;
  endtask

  task automatic wait_done(input int max, output int cycles);
    cycles = 0;
    while (op_done !== 1'b1 && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst        = 1'b0;
    op_valid   = 1'b0;
    op_code    = 3'd7;
    op_a       = '0;
    op_b       = '0;
    flush      = 1'b0;
    is_busbusy = 1'b0;
    hilo_rd    = 1'b0;
    div_lat    = 33;
    stray_done = 1'b0;
    stray_val  = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({hi, lo} !== '0) begin
      n_err++;
      $display("FAIL reset_hilo: got hi=%h lo=%h, required 0/0", hi, lo);
    end
    n_cmp++;
    if (op_ready !== 1'b1 || stall_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_handshake: got op_ready=%b stall_req=%b, required 1/0", op_ready, stall_req);
    end
    n_cmp++;
    if ({mul_ce, div_start, div_cancel, op_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got mul_ce/div_start/div_cancel/op_done=%b, required 0000",
               {mul_ce, div_start, div_cancel, op_done});
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b1;
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_mult_signed();
    int cyc;
    logic [2*W-1:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
    issue_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    n_cmp++;
    if (op_ready !== 1'b0 || mul_ce !== 1'b1 || mul_sign !== 1'b1) begin
      n_err++;
      $display("FAIL mult_launch: got op_ready=%b mul_ce=%b mul_sign=%b, required 0/1/1",
               op_ready, mul_ce, mul_sign);
    end
    wait_done(20, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (op_done !== 1'b1 || cyc != MUL_LAT + 1) begin
      n_err++;
      $display("FAIL mult_latency: got op_done=%b after %0d cycles, required 1 after %0d",
               op_done, cyc, MUL_LAT + 1);
    end
    n_cmp++;
    if ({hi, lo} !== e) begin
      n_err++;
      $display("FAIL mult_result: got hi=%h lo=%h, required %h", hi, lo, e);
    end
    model_hi = e[2*W-1:W];
    model_lo = e[W-1:0];
    @(negedge clk);
    n_cmp++;
    if (op_done !== 1'b0) begin
      n_err++;
      $display("FAIL mult_pulse: op_done got %b one cycle later, required 0", op_done);
    end
  endtask

  task automatic test_multu_busbusy();
    int   cyc;
    logic early;
    logic [2*W-1:0] e;
    early = 1'b0;
    is_busbusy = 1'b1;
    exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
    issue_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (7) begin
      @(negedge clk);
      if (op_done === 1'b1) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0 || dbg_state !== ST_HOLD || {hi, lo} !== {model_hi, model_lo}) begin
      n_err++;
      $display("FAIL multu_hold: got early_done=%b state=%0d hi=%h lo=%h, required 0/%0d/%h/%h",
               early, dbg_state, hi, lo, ST_HOLD, model_hi, model_lo);
    end
    is_busbusy = 1'b0;
    wait_done(10, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (op_done !== 1'b1 || cyc != 1) begin
      n_err++;
      $display("FAIL multu_release: got op_done=%b after %0d cycles, required 1 after 1", op_done, cyc);
    end
    n_cmp++;
    if ({hi, lo} !== e) begin
      n_err++;
      $display("FAIL multu_result: got hi=%h lo=%h, required %h", hi, lo, e);
    end
    model_hi = e[2*W-1:W];
    model_lo = e[W-1:0];
    @(negedge clk);
  endtask

  task automatic test_div_signed();
    int cyc;
    logic [2*W-1:0] e;
    div_lat = 33;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    n_cmp++;
    if (div_start !== 1'b1 || div_sign !== 1'b1 || div_a !== 32'hFFFF_FFF9 || div_b !== 32'd2) begin
      n_err++;
      $display("FAIL div_launch: got start=%b sign=%b a=%h b=%h, required 1/1/fffffff9/00000002",
               div_start, div_sign, div_a, div_b);
    end
    hilo_rd = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall_req !== 1'b1 || op_ready !== 1'b0 || div_start !== 1'b0) begin
      n_err++;
      $display("FAIL div_stall: got stall_req=%b op_ready=%b div_start=%b, required 1/0/0",
               stall_req, op_ready, div_start);
    end
    hilo_rd = 1'b0;
    #1;
    n_cmp++;
    if (stall_req !== 1'b0) begin
      n_err++;
      $display("FAIL div_nostall: got stall_req=%b with no request, required 0", stall_req);
    end
    wait_done(100, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (op_done !== 1'b1 || {hi, lo} !== e) begin
      n_err++;
      $display("FAIL div_result: got op_done=%b hi=%h lo=%h, required 1 %h", op_done, hi, lo, e);
    end
    model_hi = e[2*W-1:W];
    model_lo = e[W-1:0];
    @(negedge clk);
  endtask

  task automatic test_divu_zero();
    int cyc;
    logic [2*W-1:0] e;
    exp_q.push_back({model_hi, model_lo});
    issue_op(OP_DIVU, 32'd9, 32'd0);
    n_cmp++;
    if (div_start !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL divz_nolaunch: got div_start=%b state=%0d, required 0/%0d", div_start, dbg_state, ST_IDLE);
    end
    wait_done(2, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (op_done !== 1'b1 || cyc != 0 || {hi, lo} !== e) begin
      n_err++;
      $display("FAIL divz_done: got op_done=%b cyc=%0d hi=%h lo=%h, required 1 0 %h", op_done, cyc, hi, lo, e);
    end
    @(negedge clk);
    n_cmp++;
    if (op_done !== 1'b0 || div_start !== 1'b0) begin
      n_err++;
      $display("FAIL divz_after: got op_done=%b div_start=%b, required 0/0", op_done, div_start);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic saw;
    saw      = 1'b0;
    op_valid = 1'b1;
    op_code  = OP_MTHI;
    op_a     = 32'h0000_1234;
    @(negedge clk);
    if (op_done === 1'b1) saw = 1'b1;
    op_code = OP_MTLO;
    op_a    = 32'h0000_ABCD;
    @(negedge clk);
    if (op_done === 1'b1) saw = 1'b1;
    op_valid = 1'b0;
    op_code  = 3'd7;
    model_hi = 32'h0000_1234;
    model_lo = 32'h0000_ABCD;
    n_cmp++;
    if ({hi, lo} !== {model_hi, model_lo} || saw !== 1'b0) begin
      n_err++;
      $display("FAIL mt_write: got hi=%h lo=%h op_done_seen=%b, required %h %h 0", hi, lo, saw, model_hi, model_lo);
    end
  endtask

  task automatic test_flush_div();
    logic saw;
    saw     = 1'b0;
    div_lat = 33;
    issue_op(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (div_cancel !== 1'b1 || dbg_state !== ST_IDLE || op_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_cancel: got div_cancel=%b state=%0d op_ready=%b, required 1/%0d/1",
               div_cancel, dbg_state, op_ready, ST_IDLE);
    end
    @(negedge clk);
    n_cmp++;
    if (div_cancel !== 1'b0) begin
      n_err++;
      $display("FAIL flush_pulse: div_cancel got %b one cycle later, required 0", div_cancel);
    end
    stray_val  = 32'h5A5A_5A5A;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (op_done === 1'b1 || dbg_state !== ST_IDLE) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0 || {hi, lo} !== {model_hi, model_lo}) begin
      n_err++;
      $display("FAIL flush_stray: got disturbed=%b hi=%h lo=%h, required 0 %h %h", saw, hi, lo, model_hi, model_lo);
    end
    // An op presented together with flush in IDLE is dropped.
    op_valid = 1'b1;
    op_code  = OP_MULT;
    op_a     = 32'd3;
    op_b     = 32'd3;
    flush    = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'd7;
    flush    = 1'b0;
    n_cmp++;
    if (mul_ce !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL flush_idle: got mul_ce=%b state=%0d, required 0/%0d", mul_ce, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_flush_hold();
    logic saw;
    saw        = 1'b0;
    is_busbusy = 1'b1;
    issue_op(OP_MULT, 32'd7, 32'd9);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (dbg_state !== ST_HOLD) begin
      n_err++;
      $display("FAIL hold_reach: got state=%0d, required %0d", dbg_state, ST_HOLD);
    end
    flush      = 1'b1;
    is_busbusy = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    if (op_done === 1'b1) saw = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (op_done === 1'b1) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0 || dbg_state !== ST_IDLE || {hi, lo} !== {model_hi, model_lo}) begin
      n_err++;
      $display("FAIL hold_flush: got op_done_seen=%b state=%0d hi=%h lo=%h, required 0/%0d %h %h",
               saw, dbg_state, hi, lo, ST_IDLE, model_hi, model_lo);
    end
  endtask

  task automatic test_back_to_back();
    int             cyc;
    logic [2:0]     c;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] e;
    for (int i = 0; i < 8; i++) begin
      c = 3'($urandom_range(0, 3));
      a = $urandom;
      if (c == OP_DIV || c == OP_DIVU) begin
        b       = 32'($urandom_range(1, 5000));
        div_lat = $urandom_range(2, 12);
        exp_q.push_back(ref_div(a, b, c == OP_DIV));
      end else begin
        b = $urandom;
        exp_q.push_back(ref_mul(a, b, c == OP_MULT));
      end
      issue_op(c, a, b);
      wait_done(60, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (op_done !== 1'b1 || {hi, lo} !== e) begin
        n_err++;
        $display("FAIL b2b[%0d] code=%0d a=%h b=%h: got op_done=%b hi=%h lo=%h, required 1 %h",
                 i, c, a, b, op_done, hi, lo, e);
      end
      model_hi = e[2*W-1:W];
      model_lo = e[W-1:0];
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    issue_op(OP_MULT, 32'd3, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({hi, lo} !== '0 || {mul_ce, div_start, div_cancel, op_done} !== 4'b0000 ||
        op_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_mid_mul: got hi=%h lo=%h ctrl=%b op_ready=%b state=%0d, required 0 0 0000 1 %0d",
               hi, lo, {mul_ce, div_start, div_cancel, op_done}, op_ready, dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst = 1'b1;
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult_signed();
    test_multu_busbusy();
    test_div_signed();
    test_divu_zero();
    test_mthi_mtlo();
    test_flush_div();
    test_flush_hold();
    test_back_to_back();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
